// File: rtl/sfr_pkg.sv
// Shared types for the SFR bus master: FSM states, captured command and response records.
package sfr_pkg;

  localparam int SFR_ADDR_W = 32;
  localparam int SFR_DATA_W = 32;
  localparam int SFR_STRB_W = SFR_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    RD_REQ = 3'd2,
    RSP    = 3'd3,
    GAP    = 3'd4
  } sfr_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [SFR_ADDR_W-1:0] addr;
    logic [SFR_DATA_W-1:0] wdata;
    logic [SFR_STRB_W-1:0] strobe;
  } sfr_cmd_t;

  typedef struct packed {
    logic                  write;
    logic [SFR_DATA_W-1:0] rdata;
    logic                  error;
  } sfr_rsp_t;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/sfr_timeout_ctr.sv
// Request-hold timer: counts cycles while enabled; expired is high during the last allowed cycle.
module sfr_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  // Flagging one cycle early lets the master leave on the edge where count would reach LIMIT.
  assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/sfr_bus_master.sv
// SFR bus initiator: one command at a time, drives wr_en/rd_en until ack or timeout, returns a response.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// WR_REQ | o_wr_en driven, waiting for i_wready or timeout
// RD_REQ | o_rd_en driven, waiting for i_rvalid or timeout
// RSP    | rsp_valid high, holding response until rsp_ready
// GAP    | one dead cycle, late acks from the slave ignored
module sfr_bus_master
  import sfr_pkg::*;
#(
  parameter int ADDR_W         = SFR_ADDR_W,
  parameter int DATA_W         = SFR_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strobe,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                o_wr_en,
  output logic                o_rd_en,
  output logic [ADDR_W-1:0]   o_waddr,
  output logic [ADDR_W-1:0]   o_raddr,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrobe,
  input  logic                i_wready,
  input  logic                i_rvalid,
  input  logic [DATA_W-1:0]   i_rdata
);

  sfr_mst_state_e state, state_next;
  sfr_cmd_t       cmd_q;
  sfr_rsp_t       rsp_q, rsp_d;
  logic           ready_q;
  logic           cmd_take;
  logic           in_req;
  logic           tmo_expired;

  assign in_req = (state == WR_REQ) || (state == RD_REQ);

  sfr_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!in_req),
    .enable  (in_req),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
      rsp_q   <= rsp_d;
      if (cmd_take) begin
        cmd_q <= '{write:  cmd_write,
                   addr:   SFR_ADDR_W'(cmd_addr),
                   wdata:  SFR_DATA_W'(cmd_wdata),
                   strobe: SFR_STRB_W'(cmd_strobe)};
      end
    end
  end

  always_comb begin
    state_next = state;
    cmd_take   = 1'b0;
    rsp_d      = rsp_q;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_take = 1'b1;
          if (addr_misaligned(cmd_addr[1:0])) begin
            state_next = RSP;
            rsp_d      = '{write: cmd_write, rdata: '0, error: 1'b1};
          end else if (cmd_write) begin
            state_next = WR_REQ;
          end else begin
            state_next = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // Ack is checked first so an ack on the timeout edge still completes cleanly.
        if (i_wready) begin
          state_next = RSP;
          rsp_d      = '{write: 1'b1, rdata: '0, error: 1'b0};
        end else if (tmo_expired) begin
          state_next = RSP;
          rsp_d      = '{write: cmd_q.write, rdata: '0, error: 1'b1};
        end
      end
      RD_REQ: begin
        if (i_rvalid) begin
          state_next = RSP;
          rsp_d      = '{write: 1'b0, rdata: SFR_DATA_W'(i_rdata), error: 1'b0};
        end else if (tmo_expired) begin
          state_next = RSP;
          rsp_d      = '{write: cmd_q.write, rdata: '0, error: 1'b1};
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus and response outputs decode registers only, so nothing combinational reaches them from inputs.
  assign cmd_ready = ready_q;
  assign rsp_valid = (state == RSP);
  assign rsp_write = rsp_q.write;
  assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
  assign rsp_error = rsp_q.error;
  assign o_wr_en   = (state == WR_REQ);
  assign o_rd_en   = (state == RD_REQ);
  assign o_waddr   = cmd_q.addr[ADDR_W-1:0];
  assign o_raddr   = cmd_q.addr[ADDR_W-1:0];
  assign o_wdata   = cmd_q.wdata[DATA_W-1:0];
  assign o_wstrobe = cmd_q.strobe[DATA_W/8-1:0];

endmodule

// File: tb/tb_sfr_bus_master.sv
// Directed bench for sfr_bus_master with a small programmable-latency SFR slave.
module tb_sfr_bus_master;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strobe;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        o_wr_en;
  logic        o_rd_en;
  logic [31:0] o_waddr;
  logic [31:0] o_raddr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrobe;
  logic        i_wready;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  int tests;
  int fails;

  // slave controls
  logic ack_on;
  int   ack_wait;
  logic ack_linger;

  sfr_bus_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strobe (cmd_strobe),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .o_wr_en    (o_wr_en),
    .o_rd_en    (o_rd_en),
    .o_waddr    (o_waddr),
    .o_raddr    (o_raddr),
    .o_wdata    (o_wdata),
    .o_wstrobe  (o_wstrobe),
    .i_wready   (i_wready),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: acks after ack_wait request cycles; optionally holds the ack one cycle past the request.
  logic [31:0] mem [16];
  logic        mem_init = 1'b0;
  logic        linger   = 1'b0;
  int          req_age  = 0;

  always @(posedge clk) begin
    #2;
    if (!mem_init) begin
      foreach (mem[k]) mem[k] = 32'h0;
      mem_init = 1'b1;
    end
    if (o_wr_en || o_rd_en) begin
      i_wready = o_wr_en && ack_on && (req_age == ack_wait);
      i_rvalid = o_rd_en && ack_on && (req_age == ack_wait);
      i_rdata  = i_rvalid ? mem[o_raddr[5:2]] : 32'hDEAD_BEEF;
      if (i_wready) begin
        for (int b = 0; b < 4; b++)
          if (o_wstrobe[b]) mem[o_waddr[5:2]][8*b +: 8] = o_wdata[8*b +: 8];
      end
      linger  = ack_linger && (i_wready || i_rvalid);
      req_age = req_age + 1;
    end else begin
      if (!linger) begin
        i_wready = 1'b0;
        i_rvalid = 1'b0;
      end
      linger  = 1'b0;
      req_age = 0;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    cmd_write  = w;
    cmd_addr   = a;
    cmd_wdata  = d;
    cmd_strobe = s;
    cmd_valid  = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({cmd_ready, rsp_valid, rsp_write, rsp_error, o_wr_en, o_rd_en} !== 6'b0 ||
        rsp_rdata !== 32'h0 || o_waddr !== 32'h0 || o_raddr !== 32'h0 ||
        o_wdata !== 32'h0 || o_wstrobe !== 4'h0) begin
      fails++;
      $display("FAIL reset_outputs: ctl=%b rdata=%h waddr=%h wdata=%h strb=%h required all 0",
               {cmd_ready, rsp_valid, rsp_write, rsp_error, o_wr_en, o_rd_en},
               rsp_rdata, o_waddr, o_wdata, o_wstrobe);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    ack_on = 1'b1; ack_wait = 0; ack_linger = 1'b0; rsp_ready = 1'b1;
    issue(1'b1, 32'h4, 32'hA5A5_0001, 4'hF);
    @(negedge clk);
    tests++;
    if ({o_wr_en, o_rd_en, rsp_valid, cmd_ready} !== 4'b1000 || o_waddr !== 32'h4 ||
        o_wdata !== 32'hA5A5_0001 || o_wstrobe !== 4'hF) begin
      fails++;
      $display("FAIL wr_request: wr/rd/rv/rdy=%b addr=%h data=%h strb=%h required 1000 4 a5a50001 f",
               {o_wr_en, o_rd_en, rsp_valid, cmd_ready}, o_waddr, o_wdata, o_wstrobe);
    end
    @(negedge clk);
    tests++;
    if ({o_wr_en, rsp_valid, rsp_write, rsp_error} !== 4'b0110 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL wr_response: wr/rv/rw/err=%b rdata=%h required 0110 0", {o_wr_en, rsp_valid, rsp_write, rsp_error}, rsp_rdata);
    end
    @(negedge clk);
    tests++;
    if ({o_wr_en, rsp_valid, cmd_ready} !== 3'b000) begin
      fails++;
      $display("FAIL wr_gap: wr/rv/rdy=%b required 000", {o_wr_en, rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read();
    ack_on = 1'b1; ack_wait = 0; ack_linger = 1'b0; rsp_ready = 1'b1;
    issue(1'b0, 32'h4, 32'h0, 4'h0);
    @(negedge clk);
    tests++;
    if ({o_rd_en, o_wr_en} !== 2'b10 || o_raddr !== 32'h4) begin
      fails++;
      $display("FAIL rd_request: rd/wr=%b raddr=%h required 10 4", {o_rd_en, o_wr_en}, o_raddr);
    end
    @(negedge clk);
    tests++;
    if ({o_rd_en, rsp_valid, rsp_write, rsp_error} !== 4'b0100 || rsp_rdata !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL rd_response: rd/rv/rw/err=%b rdata=%h required 0100 a5a50001",
               {o_rd_en, rsp_valid, rsp_write, rsp_error}, rsp_rdata);
    end
  endtask

  task automatic test_timeout();
    int held;
    ack_on = 1'b0; rsp_ready = 1'b1;
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    held = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_rd_en !== 1'b1) break;
      held++;
    end
    tests++;
    if (held !== 16) begin
      fails++;
      $display("FAIL tmo_hold_cycles: o_rd_en held %0d cycles required 16", held);
    end
    tests++;
    if ({rsp_valid, rsp_write, rsp_error} !== 3'b101 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL tmo_response: rv/rw/err=%b rdata=%h required 101 0", {rsp_valid, rsp_write, rsp_error}, rsp_rdata);
    end
    ack_on = 1'b1;
  endtask

  task automatic test_misaligned();
    ack_on = 1'b1; ack_wait = 0; rsp_ready = 1'b1;
    issue(1'b1, 32'h6, 32'h1234_5678, 4'hF);
    @(negedge clk);
    tests++;
    if ({o_wr_en, rsp_valid, rsp_write, rsp_error} !== 4'b0111 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL misaligned_rsp: wr/rv/rw/err=%b rdata=%h required 0111 0",
               {o_wr_en, rsp_valid, rsp_write, rsp_error}, rsp_rdata);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (o_wr_en !== 1'b0 || rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL misaligned_no_bus: cycle %0d wr/rv=%b required 00", i, {o_wr_en, rsp_valid});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b_addr  [4] = '{32'h20, 32'h20, 32'h24, 32'h24};
    logic        b_wr    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] b_data  [4] = '{32'h1111_0000, 32'h0, 32'hCAFE_F00D, 32'h0};
    logic [3:0]  b_strb  [4] = '{4'hF, 4'h0, 4'h5, 4'h0};
    logic [31:0] b_rdata [4] = '{32'h0, 32'h1111_0000, 32'h0, 32'h00FE_000D};
    int acc_cyc [4];
    int rsp_cyc [4];
    int cyc, idx, r;
    logic pending;

    ack_on = 1'b1; ack_wait = 1; ack_linger = 1'b1; rsp_ready = 1'b0;
    issue(1'b1, 32'h10, 32'h1234_5678, 4'h3);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_error, rsp_write, cmd_ready} !== 4'b1010 || rsp_rdata !== 32'h0) begin
        fails++;
        $display("FAIL stall_stable: cycle %0d rv/err/rw/rdy=%b rdata=%h required 1010 0",
                 i, {rsp_valid, rsp_error, rsp_write, cmd_ready}, rsp_rdata);
      end
    end
    rsp_ready = 1'b1;

    idx = 0; r = 0; cyc = 0; pending = 1'b0;
    cmd_write = b_wr[0]; cmd_addr = b_addr[0]; cmd_wdata = b_data[0]; cmd_strobe = b_strb[0];
    cmd_valid = 1'b1;
    while (r < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (pending) begin
        idx++;
        pending = 1'b0;
        if (idx < 4) begin
          cmd_write = b_wr[idx]; cmd_addr = b_addr[idx]; cmd_wdata = b_data[idx]; cmd_strobe = b_strb[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (rsp_valid === 1'b1) begin
        rsp_cyc[r] = cyc;
        tests++;
        if (rsp_write !== b_wr[r] || rsp_error !== 1'b0 || rsp_rdata !== b_rdata[r]) begin
          fails++;
          $display("FAIL b2b_rsp%0d: rw=%b err=%b rdata=%h required %b 0 %h",
                   r, rsp_write, rsp_error, rsp_rdata, b_wr[r], b_rdata[r]);
        end
        r++;
      end
      if (cmd_valid && cmd_ready === 1'b1 && idx < 4) begin
        acc_cyc[idx] = cyc;
        pending = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    tests++;
    if (r !== 4) begin
      fails++;
      $display("FAIL b2b_count: %0d responses required 4 within 100 cycles", r);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (rsp_cyc[i] - acc_cyc[i] !== 3) begin
          fails++;
          $display("FAIL b2b_latency%0d: %0d cycles required 3", i, rsp_cyc[i] - acc_cyc[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (acc_cyc[i+1] - acc_cyc[i] !== 5) begin
          fails++;
          $display("FAIL b2b_spacing%0d: %0d cycles required 5", i, acc_cyc[i+1] - acc_cyc[i]);
        end
      end
    end
    ack_linger = 1'b0;
  endtask

  task automatic test_reset_mid();
    ack_on = 1'b0; rsp_ready = 1'b1;
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    tests++;
    if (o_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL mid_rd_active: o_rd_en=%b required 1", o_rd_en);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({o_rd_en, o_wr_en, rsp_valid, cmd_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL mid_async_drop: rd/wr/rv/rdy=%b required 0000", {o_rd_en, o_wr_en, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({o_rd_en, rsp_valid, cmd_ready} !== 3'b001) begin
        fails++;
        $display("FAIL mid_idle_after: cycle %0d rd/rv/rdy=%b required 001", i, {o_rd_en, rsp_valid, cmd_ready});
      end
    end
    ack_on = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_strobe = 4'h0;
    rsp_ready = 1'b1;
    i_wready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0;
    ack_on = 1'b1; ack_wait = 0; ack_linger = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
